// File: rtl/soft_err_pkg.sv
// soft_err_pkg: shared FSM state type, channel indices and default channel count
package soft_err_pkg;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPARE, S_UPDATE, S_DONE} state_t;
   localparam int NUM_CHAN_DEF     = 3;
   localparam int CH_DATA_CORRUPT  = 0;
   localparam int CH_UNKNOWN_TTC   = 1;
   localparam int CH_DDR3_OVERFLOW = 2;
endpackage

// File: rtl/soft_err_compare.sv
// soft_err_compare: registered trip/warn decision for one snapshot count/threshold pair
module soft_err_compare #(
   parameter int CNT_WIDTH  = 32,
   parameter int WARN_SHIFT = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [CNT_WIDTH-1:0] count,
   input  logic [CNT_WIDTH-1:0] thres,
   output logic                 trip,
   output logic                 warn
);
   logic trip_d, trip_q, warn_d, warn_q;
   always_comb begin
      trip_d = (thres != '0) && (count >= thres);
      warn_d = (thres != '0) && (count >= thres - (thres >> WARN_SHIFT));
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         trip_q <= 1'b0;
         warn_q <= 1'b0;
      end else begin
         trip_q <= trip_d;
         warn_q <= warn_d;
      end
   end
   assign trip = trip_q;
   assign warn = warn_q;
endmodule

// File: rtl/soft_error_monitor.sv
// soft_error_monitor: scans soft-error counters against thresholds, raising sticky errors and warnings
module soft_error_monitor
   import soft_err_pkg::*;
#(
   parameter int NUM_CHAN   = NUM_CHAN_DEF,
   parameter int CNT_WIDTH  = 32,
   parameter int WARN_SHIFT = 2
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic                          clear_errors,
   input  logic [NUM_CHAN*CNT_WIDTH-1:0] thres_vec,
   input  logic [NUM_CHAN*CNT_WIDTH-1:0] count_vec,
   output logic [NUM_CHAN-1:0]           error_out,
   output logic [NUM_CHAN-1:0]           warning_out,
   output logic                          first_err_valid,
   output logic [$clog2(NUM_CHAN)-1:0]   first_err_chan,
   output logic                          scan_done,
   output logic [$clog2(NUM_CHAN)-1:0]   scan_index
);
   localparam int IW = $clog2(NUM_CHAN);
   state_t state_d, state_q;
   logic [IW-1:0] idx_d, idx_q, fc_d, fc_q;
   logic [CNT_WIDTH-1:0] cnt_d, cnt_q, thr_d, thr_q;
   logic [NUM_CHAN-1:0] err_d, err_q, warn_d, warn_q;
   logic fv_d, fv_q, done_d, done_q, trip, warn;
   soft_err_compare #(.CNT_WIDTH(CNT_WIDTH), .WARN_SHIFT(WARN_SHIFT)) u_cmp (
      .clk(clk), .reset_n(reset_n), .count(cnt_q), .thres(thr_q), .trip(trip), .warn(warn)
   );
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      thr_d   = thr_q;
      warn_d  = warn_q;
      err_d   = clear_errors ? '0 : err_q;
      fv_d    = clear_errors ? 1'b0 : fv_q;
      fc_d    = clear_errors ? '0 : fc_q;
      case (state_q)
         S_IDLE: if (enable) begin
            state_d = S_LOAD;
            idx_d   = '0;
         end
         S_LOAD: begin
            cnt_d   = count_vec[idx_q*CNT_WIDTH +: CNT_WIDTH];
            thr_d   = thres_vec[idx_q*CNT_WIDTH +: CNT_WIDTH];
            state_d = S_COMPARE;
         end
         S_COMPARE: state_d = S_UPDATE;
         S_UPDATE: begin
            err_d[idx_q]  = err_d[idx_q] | trip;
            warn_d[idx_q] = warn;
            // a trip in the same cycle as a clear still becomes the first error
            if (trip && !fv_d) begin
               fv_d = 1'b1;
               fc_d = idx_q;
            end
            if (!enable) state_d = S_IDLE;
            else if (idx_q == IW'(NUM_CHAN-1)) state_d = S_DONE;
            else begin
               idx_d   = idx_q + IW'(1);
               state_d = S_LOAD;
            end
         end
         S_DONE: begin
            state_d = enable ? S_LOAD : S_IDLE;
            idx_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase
      done_d = (state_d == S_DONE);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         thr_q   <= '0;
         err_q   <= '0;
         warn_q  <= '0;
         fv_q    <= 1'b0;
         fc_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         thr_q   <= thr_d;
         err_q   <= err_d;
         warn_q  <= warn_d;
         fv_q    <= fv_d;
         fc_q    <= fc_d;
         done_q  <= done_d;
      end
   end
   assign error_out       = err_q;
   assign warning_out     = warn_q;
   assign first_err_valid = fv_q;
   assign first_err_chan  = fc_q;
   assign scan_done       = done_q;
   assign scan_index      = idx_q;
endmodule

// File: tb/tb_soft_error_monitor.sv
// tb_soft_error_monitor: directed and random checks of soft_error_monitor against a scan-position model
module tb_soft_error_monitor;
   import soft_err_pkg::*;
   localparam int N = 3;
   localparam int W = 32;
   logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, clear_errors = 1'b0;
   logic [N*W-1:0] thres_vec = '0, count_vec = '0;
   logic [N-1:0] error_out, warning_out;
   logic first_err_valid, scan_done;
   logic [1:0] first_err_chan, scan_index;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   soft_error_monitor dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .clear_errors(clear_errors),
      .thres_vec(thres_vec), .count_vec(count_vec), .error_out(error_out),
      .warning_out(warning_out), .first_err_valid(first_err_valid),
      .first_err_chan(first_err_chan), .scan_done(scan_done), .scan_index(scan_index)
   );
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // Model: pos = -1 idle, 0..3N-1 walks (channel, step), 3N is the scan-done cycle
   int pos = -1, m_fc = 0, ch;
   logic [N-1:0] m_err = '0, m_warn = '0;
   logic m_fv = 1'b0, m_done = 1'b0, p_trip = 1'b0, p_warn = 1'b0;
   logic [W-1:0] c, t;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pos = -1; m_err = '0; m_warn = '0; m_fv = 1'b0; m_fc = 0; m_done = 1'b0;
      end else begin
         ch = pos / 3;
         if (clear_errors) begin
            m_err = '0; m_fv = 1'b0; m_fc = 0;
         end
         if (pos < 0 || pos == 3*N) pos = enable ? 0 : -1;
         else if (pos % 3 == 0) begin
            c = count_vec[ch*W +: W];
            t = thres_vec[ch*W +: W];
            p_trip = (t != 0) && (c >= t);
            p_warn = (t != 0) && (c >= t - t / 4);
            pos++;
         end else if (pos % 3 == 1) pos++;
         else begin
            m_err[ch] = m_err[ch] | p_trip;
            m_warn[ch] = p_warn;
            if (p_trip && !m_fv) begin
               m_fv = 1'b1; m_fc = ch;
            end
            pos = !enable ? -1 : (ch == N-1 ? 3*N : pos + 1);
         end
         m_done = (pos == 3*N);
      end
   end
   always @(negedge clk) if (reset_n) begin
      chk("error_out", error_out, m_err);
      chk("warning_out", warning_out, m_warn);
      chk("first_err_valid", first_err_valid, m_fv);
      chk("first_err_chan", first_err_chan, m_fc);
      chk("scan_done", scan_done, m_done);
      if (pos >= 0 && pos < 3*N) chk("scan_index", scan_index, pos / 3);
   end
   task automatic set_ch(input int i, input logic [W-1:0] th, input logic [W-1:0] cn);
      thres_vec[i*W +: W] = th;
      count_vec[i*W +: W] = cn;
   endtask
   task automatic wait_done(input string name, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!scan_done && n < 40);
      chk(name, scan_done, 1);
   endtask
   initial begin
      int n;
      bit seen;
      repeat (2) @(negedge clk);
      chk("rst error_out", error_out, 0);
      chk("rst warning_out", warning_out, 0);
      chk("rst first_valid", first_err_valid, 0);
      chk("rst first_chan", first_err_chan, 0);
      chk("rst scan_done", scan_done, 0);
      chk("rst scan_index", scan_index, 0);
      set_ch(CH_DATA_CORRUPT, 100, 99);
      reset_n = 1'b1;
      enable = 1'b1;
      repeat (2) wait_done("t1 done", n);
      chk("t1 99 no err", error_out, 0);
      chk("t1 99 warn", warning_out, 3'b001);
      set_ch(CH_DATA_CORRUPT, 100, 75);
      repeat (2) wait_done("t1 done", n);
      chk("t1 75 warn", warning_out, 3'b001);
      set_ch(CH_DATA_CORRUPT, 100, 74);
      repeat (2) wait_done("t1 done", n);
      chk("t1 74 no warn", warning_out, 0);
      set_ch(CH_DATA_CORRUPT, 100, 100);
      n = 0;
      while (!error_out[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t1 err within 20", error_out, 3'b001);
      chk("t1 first chan", first_err_chan, 0);
      chk("t1 first valid", first_err_valid, 1);
      set_ch(CH_DATA_CORRUPT, 100, 0);
      repeat (2) wait_done("t1 done", n);
      chk("t1 sticky err", error_out, 3'b001);
      chk("t1 warn cleared", warning_out, 0);
      clear_errors = 1'b1;
      @(negedge clk);
      clear_errors = 1'b0;
      chk("clr err", error_out, 0);
      chk("clr first valid", first_err_valid, 0);
      for (int i = 0; i < N; i++) set_ch(i, 0, 32'hFFFF_FFFF);
      wait_done("t2 align", n);
      for (int s = 0; s < 5; s++) begin
         wait_done("t2 done", n);
         chk("t2 period", n, 10);
         chk("t2 no err", error_out, 0);
         chk("t2 no warn", warning_out, 0);
      end
      set_ch(0, 50, 0);
      set_ch(1, 50, 60);
      set_ch(2, 50, 60);
      wait_done("t3 done", n);
      chk("t3 err", error_out, 3'b110);
      chk("t3 first chan", first_err_chan, 1);
      chk("t3 first valid", first_err_valid, 1);
      set_ch(1, 50, 0);
      repeat (9) @(negedge clk);
      chk("t4 at ch2", scan_index, 2);
      clear_errors = 1'b1;
      @(negedge clk);
      clear_errors = 1'b0;
      chk("t4 err", error_out, 3'b100);
      chk("t4 first chan", first_err_chan, 2);
      chk("t4 first valid", first_err_valid, 1);
      chk("t4 done", scan_done, 1);
      repeat (5) @(negedge clk);
      enable = 1'b0;
      chk("t5 at ch1", scan_index, 1);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen |= scan_done;
      end
      chk("t5 no done", seen, 0);
      enable = 1'b1;
      @(negedge clk);
      chk("t5 restart ch0", scan_index, 0);
      wait_done("t6 done", n);
      repeat (4) @(negedge clk);
      chk("t6 err latched", error_out, 3'b100);
      #2 reset_n = 1'b0;
      #1;
      chk("t6 async err", error_out, 0);
      chk("t6 async warn", warning_out, 0);
      chk("t6 async valid", first_err_valid, 0);
      chk("t6 async chan", first_err_chan, 0);
      chk("t6 async index", scan_index, 0);
      @(negedge clk);
      reset_n = 1'b1;
      n = 1;
      do begin
         @(negedge clk);
         n++;
      end while (!scan_done && n < 30);
      chk("t6 first done cycle", n, 11);
      for (int k = 0; k < 800; k++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) begin
            int i = $urandom_range(0, N-1);
            logic [W-1:0] th = ($urandom_range(0, 3) == 0) ? 0 : W'($urandom_range(1, 40));
            if ($urandom_range(0, 15) == 0) set_ch(i, 32'hFFFF_FFFF, 32'hFFFF_FFFF - W'($urandom_range(0, 1)));
            else set_ch(i, th, W'($urandom_range(0, 45)));
         end
         clear_errors = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 39) == 0) enable = ~enable;
         else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      end
      clear_errors = 1'b0;
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/soft_error_monitor.md
# soft_error_monitor

Sequencer that scans the soft-error counters (checksum mismatch, unknown TTC command, DDR3 overflow) one channel at a time against their programmable thresholds. It raises sticky hard-error flags and non-sticky early warnings. It sits between the counter sources / threshold configuration registers and the status register block, where it drives `error_data_corrupt`, `error_unknown_ttc` and `ddr3_overflow_warning`-class inputs.

## Interface
- `NUM_CHAN`, 3: number of counter/threshold pairs scanned (channel 0 = data corrupt, 1 = unknown TTC, 2 = DDR3 overflow).
- `CNT_WIDTH`, 32: width of each counter and threshold.
- `WARN_SHIFT`, 2: warning level is `thres - (thres >> WARN_SHIFT)`, i.e. 75 % of threshold by default.

- `clk` input 1: single clock for all logic.
- `reset_n` input 1: asynchronous, active-low reset.
- `enable` input 1: level; scanning runs while high.
- `clear_errors` input 1: one-cycle pulse; clears sticky errors and first-error capture.
- `thres_vec` input NUM_CHAN*CNT_WIDTH: thresholds; channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH]; value 0 disables the channel.
- `count_vec` input NUM_CHAN*CNT_WIDTH: live counters, same packing.
- `error_out` output NUM_CHAN: sticky per-channel hard error.
- `warning_out` output NUM_CHAN: per-channel warning, refreshed every scan.
- `first_err_valid` output 1: a first error has been captured since reset/clear.
- `first_err_chan` output clog2(NUM_CHAN): channel that tripped first.
- `scan_done` output 1: one-cycle pulse at the end of each full scan.
- `scan_index` output clog2(NUM_CHAN): channel currently being processed.

## Operation
- FSM states: IDLE, LOAD, COMPARE, UPDATE, DONE.
- IDLE: leaves to LOAD with `scan_index` = 0 when `enable` = 1.
- LOAD: registers count[i] and thres[i] into snapshot registers, so the comparison uses one coherent sample.
- COMPARE: registers `trip = (thres != 0) && (count >= thres)` and `warn = (thres != 0) && (count >= thres - (thres >> WARN_SHIFT))`.
  - Comparison is unsigned at CNT_WIDTH bits.
  - The subtraction cannot underflow.
- UPDATE:
  - `error_out[i]` |= trip.
  - `warning_out[i]` = warn.
  - If trip and !first_err_valid: capture i into `first_err_chan` and set `first_err_valid`.
  - Then, if i = NUM_CHAN-1, go to DONE; otherwise increment index and go to LOAD.
- DONE: pulses `scan_done`, then goes to LOAD (index 0) if `enable` = 1, otherwise to IDLE.
- `enable` dropping mid-scan: the current channel completes through UPDATE, then the FSM goes directly to IDLE with no `scan_done`. Outputs hold their values.
- `clear_errors`: zeroes `error_out`, `first_err_valid` and `first_err_chan` in the cycle after the pulse.
  - If it coincides with UPDATE setting a trip, the set wins for that channel, and that channel becomes the first error.
  - It does not affect `warning_out` or the FSM.
- Disabled channel (thres = 0): never trips or warns; its warning is cleared on its UPDATE.
- Counter wrap-around is not detected; the monitor compares whatever value is sampled.

## Timing
- Reset values: all outputs 0, FSM in IDLE, `scan_index` = 0.
- Per-channel cost is 3 cycles (LOAD, COMPARE, UPDATE); a full scan is 3*NUM_CHAN+1 cycles (10 cycles at default).
- Latency from count sampled in LOAD to `error_out` high is 2 cycles.
- Worst-case latency from a counter crossing threshold to `error_out` is 2*(3*NUM_CHAN+1) cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package (`soft_err_pkg`) holds:
  - the FSM state enum;
  - channel index constants CH_DATA_CORRUPT = 0, CH_UNKNOWN_TTC = 1, CH_DDR3_OVERFLOW = 2;
  - the NUM_CHAN default.
- One natural sub-module, `soft_err_compare`: the registered comparator producing trip/warn from the snapshot count/thres with WARN_SHIFT. Everything else is flat.

## Test plan
- Threshold 100 on channel 0, count 99 → no error; count 75 → `warning_out[0]` = 1; count 100 → `error_out[0]` = 1 within 20 cycles, `first_err_chan` = 0, and the error persists after count drops to 0.
- All thresholds 0, counts 0xFFFFFFFF → `error_out` and `warning_out` stay 0 over 5 scans; `scan_done` pulses every 10 cycles.
- Channels 2 and 1 exceed threshold in the same scan → both errors set, `first_err_chan` = 1 (lower index processed first), `first_err_valid` = 1.
- `clear_errors` pulsed in the same cycle as the UPDATE that trips channel 2 → `error_out[2]` = 1, `first_err_chan` = 2; all other bits 0.
- `enable` deasserted during COMPARE of channel 1 → channel 1 UPDATE completes, FSM goes to IDLE, no `scan_done`; re-enable → scan restarts at channel 0.
- `reset_n` asserted mid-scan with errors latched → all outputs 0 asynchronously; after release with `enable` = 1 the first `scan_done` arrives 11 cycles later (1 IDLE cycle + 10 scan cycles).
